// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter driving the 4:1 mux select code,
// holding each grant for up to DWELL accepted beats before rotating priority.
module mux_sel_arbiter #(
   parameter int DWELL = 4,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       ready,
   output logic [1:0] s,
   output logic [3:0] grant,
   output logic       valid
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t             state, state_nx;
   logic [1:0]         ptr, ptr_nx, s_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [3:0]         grant_nx;
   logic               valid_nx, rel;
   logic [2:0]         hit_idle, hit_rel;
   // returns {found, index} of the first requester at or after p (mod 4)
   function automatic logic [2:0] find(input logic [1:0] p, input logic [3:0] r);
      logic [2:0] f;
      logic [1:0] idx;
      f = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) f = {1'b1, idx};
      end
      return f;
   endfunction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s     <= 2'b00;
         ptr   <= 2'b00;
         cnt   <= '0;
         grant <= 4'b0000;
         valid <= 1'b0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
         grant <= grant_nx;
         valid <= valid_nx;
      end
   end
   // a dropped request releases at once and its beat is never counted
   always_comb begin
      state_nx = state;
      s_nx     = s;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      hit_idle = find(ptr, req);
      hit_rel  = find(s + 2'd1, req);
      rel      = (state == GRANT) && (!req[s] || (ready && cnt == CNT_W'(DWELL - 1)));
      if (state == IDLE) begin
         if (hit_idle[2]) begin
            state_nx = GRANT;
            s_nx     = hit_idle[1:0];
            cnt_nx   = '0;
         end
      end else if (rel) begin
         ptr_nx   = s + 2'd1;
         cnt_nx   = '0;
         state_nx = hit_rel[2] ? GRANT : IDLE;
         s_nx     = hit_rel[2] ? hit_rel[1:0] : s;
      end else if (ready) begin
         cnt_nx = cnt + 1'b1;
      end
   end
   always_comb begin
      valid_nx = (state_nx == GRANT);
      grant_nx = valid_nx ? (4'b0001 << s_nx) : 4'b0000;
   end
endmodule
